// File: rtl/dmem_mmio_bridge.sv
// Data-side memory bridge: word RAM plus an MMIO page with GPIO, a compare timer
// and a FIFO-buffered UART transmitter. Loads are combinational; stores land at the edge.
module dmem_mmio_bridge #(
    parameter int RAM_WORDS    = 1024,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] ddata_w,
    input  logic        d_w,
    input  logic        d_r,
    output logic [31:0] ddata_r,
    output logic [7:0]  gpio_out,
    output logic        timer_irq,
    output logic        uart_tx
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    // Address decode
    logic          ram_sel, mmio_sel;
    logic [2:0]    off;
    logic [AW-1:0] ram_idx;
    logic          unused_addr;

    assign ram_sel     = (daddr[31:AW+2] == '0);
    assign mmio_sel    = (daddr[31:5] == 27'h400_0000);
    assign off         = daddr[4:2];
    assign ram_idx     = daddr[AW+1:2];
    assign unused_addr = &{1'b0, daddr[1:0]};

    logic wr_mmio, we_gpio, we_cmp, we_tstat, we_udata, we_ustat;
    assign wr_mmio  = d_w && mmio_sel;
    assign we_gpio  = wr_mmio && (off == 3'd0);
    assign we_cmp   = wr_mmio && (off == 3'd2);
    assign we_tstat = wr_mmio && (off == 3'd3);
    assign we_udata = wr_mmio && (off == 3'd4);
    assign we_ustat = wr_mmio && (off == 3'd5);

    logic [31:0] ram [RAM_WORDS];
    logic [7:0]  gpio;
    logic [31:0] tcount, tcmp;
    logic        tflag;

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [FW:0]   fcnt;
    logic          ovf, fifo_full, fifo_empty, push_ok, pop;

    uart_state_t   state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic          last_tick;

    assign fifo_full  = (fcnt == (FW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fcnt == '0);
    // A full FIFO still accepts a push when the serializer pops at the same edge
    assign push_ok    = we_udata && (!fifo_full || pop);
    assign last_tick  = (baud == BW'(CLKS_PER_BIT - 1));

    // RAM and FIFO storage carry no reset
    always_ff @(posedge clk) begin
        if (!reset && d_w && ram_sel)
            ram[ram_idx] <= ddata_w;
        if (!reset && push_ok)
            fifo_mem[wr_ptr] <= ddata_w[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio    <= '0;
            tcount  <= '0;
            tcmp    <= '1;
            tflag   <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fcnt    <= '0;
            ovf     <= 1'b0;
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            if (we_gpio)
                gpio <= ddata_w[7:0];
            tcount <= tcount + 32'd1;
            if (we_cmp)
                tcmp <= ddata_w;
            // Match set beats a same-edge write-1-clear
            if (tcount == tcmp)
                tflag <= 1'b1;
            else if (we_tstat && ddata_w[0])
                tflag <= 1'b0;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase
            if (we_udata && !push_ok)
                ovf <= 1'b1;
            else if (we_ustat && ddata_w[3])
                ovf <= 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud + 1'b1;
        bit_n   = bit_idx;
        shreg_n = shreg;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_n = fifo_mem[rd_ptr];
                    state_n = START;
                end
            end
            START: if (last_tick) begin
                state_n = DATA;
                baud_n  = '0;
                bit_n   = '0;
            end
            DATA: if (last_tick) begin
                baud_n = '0;
                bit_n  = bit_idx + 1'b1;
                if (bit_idx == 3'd7)
                    state_n = STOP;
            end
            STOP: if (last_tick) begin
                state_n = IDLE;
                baud_n  = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        case (state)
            START:   uart_tx = 1'b0;
            DATA:    uart_tx = shreg[bit_idx];
            default: uart_tx = 1'b1;
        endcase
    end

    always_comb begin
        ddata_r = '0;
        if (d_r) begin
            if (ram_sel)
                ddata_r = ram[ram_idx];
            else if (mmio_sel) begin
                case (off)
                    3'd0:    ddata_r = {24'd0, gpio};
                    3'd1:    ddata_r = tcount;
                    3'd2:    ddata_r = tcmp;
                    3'd3:    ddata_r = {31'd0, tflag};
                    3'd5:    ddata_r = {28'd0, ovf, (state != IDLE), fifo_empty, fifo_full};
                    default: ddata_r = '0;
                endcase
            end
        end
    end

    assign gpio_out  = gpio;
    assign timer_irq = tflag;

endmodule

// File: doc/dmem_mmio_bridge.md
Name: dmem_mmio_bridge

Overview:
- Data-side memory subsystem directly downstream of the pipelined core's MEM stage; consumes daddr/ddata_w/d_w/d_r and returns ddata_r in the same cycle, since the core's MEM/WB register captures it at the next edge.
- Decodes each access to one of two targets:
  - word-addressed data RAM;
  - small MMIO page containing a GPIO output register, a free-running timer with compare/IRQ, and a FIFO-buffered UART transmitter.

Parameters:
- RAM_WORDS, 1024: data RAM depth in 32-bit words; power of 2.
- CLKS_PER_BIT, 16: UART bit period in clk cycles; must be >= 2.
- FIFO_DEPTH, 4: UART TX FIFO entries; power of 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- daddr  in  32  byte address from core MEM stage
- ddata_w  in  32  store data
- d_w  in  1  store strobe
- d_r  in  1  load strobe
- ddata_r  out  32  load data, combinational from daddr/d_r
- gpio_out  out  8  GPIO output register
- timer_irq  out  1  sticky timer-match flag
- uart_tx  out  1  serial TX line, idle high

Behaviour:
- Word accesses only. daddr[1:0] ignored. One clock; reset is synchronous and active-high.
- Address map (daddr[31:2] compared):
  - RAM: daddr < RAM_WORDS*4; index = daddr[log2(RAM_WORDS)+1:2].
  - 0x8000_0000 GPIO (RW, bits[7:0]).
  - 0x8000_0004 TIMER_COUNT (RO).
  - 0x8000_0008 TIMER_CMP (RW).
  - 0x8000_000C TIMER_STAT: bit0 match flag; write 1 clears.
  - 0x8000_0010 UART_DATA: write pushes ddata_w[7:0]; reads return 0.
  - 0x8000_0014 UART_STAT (RO except bit3): bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky; write 1 clears).
  - Anything else unmapped: reads 0, writes ignored.
- Read path:
  - ddata_r is combinational and equals the selected target's value when d_r=1, else 0.
  - RAM read is asynchronous.
  - MMIO reads have no side effects.
- Write path:
  - All writes take effect at the rising edge where d_w=1.
  - If d_w and d_r are both 1, the write occurs and ddata_r returns the pre-write value.
- Reset values:
  - gpio_out=0, TIMER_COUNT=0, TIMER_CMP=0xFFFF_FFFF, match flag=0, timer_irq=0.
  - FIFO empty, overflow=0, serializer IDLE, uart_tx=1.
  - RAM contents are not reset.
  - Reset wins over a simultaneous write.
  - Reset mid-frame aborts the frame; uart_tx=1 from the next edge.
- Timer:
  - Count increments every non-reset cycle and wraps 0xFFFF_FFFF->0.
  - When count==CMP (pre-increment value), the flag is set at that edge.
  - Set and write-1-clear in the same cycle: set wins.
  - Writing TIMER_CMP takes effect from the next comparison.
  - timer_irq = flag.
- UART FIFO:
  - Push accepted when not full, or when full with a pop in the same edge.
  - Otherwise the data is dropped and overflow is set.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count width is log2(FIFO_DEPTH)+1.
- UART serializer FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: if FIFO not empty, pop at this edge, load the byte, enter START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles; 3-bit bit index.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE. A nonempty FIFO is popped on the IDLE cycle, so back-to-back frames have a 1-cycle idle gap.
  - Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state change.
  - busy = (state != IDLE).
  - Latency: write at edge k -> pop at edge k+1 -> uart_tx low after edge k+1. Frame length is 10*CLKS_PER_BIT cycles.

Test Plan:
- Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0013 -> ddata_r=0xDEADBEEF. Load 0x0000_1000 (RAM_WORDS=1024) -> 0.
- Same-cycle d_w=d_r=1 at 0x8000_0000 with ddata_w=0x1A5, old GPIO 0x3C -> ddata_r=0x3C; next cycle gpio_out=0xA5.
- Reset, write TIMER_CMP=20 at count 5 -> timer_irq rises after the edge where count==20. Write 1 to 0x8000_000C on that same edge -> flag stays 1. Write 1 on a later edge -> timer_irq=0.
- Write 0x55 to UART_DATA, CLKS_PER_BIT=16 -> uart_tx=0 for 16 cycles after pop, then 1,0,1,0,1,0,1,0 at 16 cycles each, then stop 1. UART_STAT.busy=1 throughout the frame.
- Six back-to-back UART_DATA writes with FIFO_DEPTH=4 during an active frame:
  - First byte pops, 4 queue, sixth is dropped.
  - UART_STAT = full=1, overflow=1.
  - Writing 0x8 to UART_STAT -> overflow=0.
- Assert reset mid DATA state with 2 bytes queued -> next cycle uart_tx=1, UART_STAT=0x2 (empty), and TIMER_COUNT reads 0 immediately after.
